// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer: state encoding, default
// game parameters and the BCD digit helper used by the score counter.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam int LIVES_DEFAULT       = 3;
    localparam int WAIT_FRAMES_DEFAULT = 120;
    localparam int BCD_W               = 4;

    // Next value of a single decimal digit; 9 rolls over to 0.
    function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
        return (d == BCD_W'(9)) ? '0 : d + 1'b1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter for the score display; clear beats increment and
// 99 wraps silently to 00.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    output logic [2*BCD_W-1:0]   q
);

    logic [BCD_W-1:0] units;
    logic [BCD_W-1:0] tens;

    assign units = q[BCD_W-1:0];
    assign tens  = q[2*BCD_W-1:BCD_W];

    // Tens digit only advances when the units digit rolls over from 9.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q[BCD_W-1:0] <= bcd_digit_inc(units);
            if (units == BCD_W'(9))
                q[2*BCD_W-1:BCD_W] <= bcd_digit_inc(tens);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencer for the VGA pong design: start/serve/game-over flow, the
// inter-ball countdown, lives bookkeeping and press detection on the buttons.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES       = LIVES_DEFAULT,
    parameter int WAIT_FRAMES = WAIT_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_reset,
    output logic [1:0] lives,
    output logic [7:0] score_bcd,
    output logic [1:0] game_state
);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] lives_d;
    logic       ball_reset_d;
    logic       btn_any_q;
    logic       press;
    logic       score_clr;
    logic       score_inc;

    assign press      = (|btn) & ~btn_any_q;
    assign game_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_NEWGAME;
            timer_q    <= '0;
            lives      <= 2'(LIVES);
            gra_still  <= 1'b1;
            ball_reset <= 1'b0;
            btn_any_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lives      <= lives_d;
            gra_still  <= (state_d != ST_PLAY);
            ball_reset <= ball_reset_d;
            btn_any_q  <= |btn;
        end
    end

    // A miss outranks a hit in the same cycle, so the ball loss is never masked.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        lives_d      = lives;
        ball_reset_d = 1'b0;
        score_clr    = 1'b0;
        score_inc    = 1'b0;

        case (state_q)
            ST_NEWGAME: begin
                if (press) begin
                    state_d      = ST_PLAY;
                    lives_d      = 2'(LIVES);
                    score_clr    = 1'b1;
                    ball_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    timer_d = 8'(WAIT_FRAMES);
                    if (lives > 2'd1) begin
                        state_d      = ST_NEWBALL;
                        lives_d      = lives - 2'd1;
                        ball_reset_d = 1'b1;
                    end else begin
                        state_d = ST_OVER;
                        lives_d = 2'd0;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            ST_NEWBALL, ST_OVER: begin
                if (refr_tick) begin
                    if (timer_q == 8'd1) begin
                        timer_d = 8'd0;
                        state_d = (state_q == ST_NEWBALL) ? ST_PLAY : ST_NEWGAME;
                    end else if (timer_q != 8'd0) begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
    end

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .q     (score_bcd)
    );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus a randomized
// run, all compared against an integer-level model of the game rules.
module tb_pong_game_ctrl;

    localparam int LIVES_P = 3;
    localparam int WAIT_P  = 120;
    localparam int M_NEWGAME = 0, M_PLAY = 1, M_NEWBALL = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic       refr_tick, hit, miss;
    logic       gra_still, ball_reset;
    logic [1:0] lives;
    logic [7:0] score_bcd;
    logic [1:0] game_state;

    int checks = 0;
    int errors = 0;

    // Game-level model: scores as a plain integer, timer as frames remaining.
    int m_state, m_lives, m_score, m_timer;
    bit m_btn_q, m_ball;

    pong_game_ctrl #(.LIVES(LIVES_P), .WAIT_FRAMES(WAIT_P)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .refr_tick  (refr_tick),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .ball_reset (ball_reset),
        .lives      (lives),
        .score_bcd  (score_bcd),
        .game_state (game_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_state = M_NEWGAME;
        m_lives = LIVES_P;
        m_score = 0;
        m_timer = 0;
        m_btn_q = 1'b0;
        m_ball  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle 1 ns.
    task automatic step(input logic [1:0] b, input logic t, input logic h, input logic m);
        bit p;
        btn = b; refr_tick = t; hit = h; miss = m;
        @(posedge clk);
        p = (b != 2'b00) && !m_btn_q;
        m_btn_q = (b != 2'b00);
        m_ball = 1'b0;
        case (m_state)
            M_NEWGAME: if (p) begin
                m_state = M_PLAY; m_lives = LIVES_P; m_score = 0; m_ball = 1'b1;
            end
            M_PLAY: if (m) begin
                m_timer = WAIT_P;
                if (m_lives > 1) begin
                    m_lives--; m_state = M_NEWBALL; m_ball = 1'b1;
                end else begin
                    m_lives = 0; m_state = M_OVER;
                end
            end else if (h) begin
                m_score = (m_score + 1) % 100;
            end
            default: if (t) begin
                if (m_timer == 1) begin
                    m_timer = 0;
                    m_state = (m_state == M_NEWBALL) ? M_PLAY : M_NEWGAME;
                end else if (m_timer > 0) begin
                    m_timer--;
                end
            end
        endcase
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
        model_reset();
        #100;
        checks++;
        if (game_state !== 2'b00 || gra_still !== 1'b1 || ball_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl state=%b still=%b ball=%b expected 00 1 0",
                     game_state, gra_still, ball_reset);
        end
        checks++;
        if (lives !== 2'd3 || score_bcd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data lives=%0d score=%h expected 3 00", lives, score_bcd);
        end
        reset = 1'b0;
    endtask

    task automatic test_start();
        step(2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'b01 || gra_still !== 1'b0 || lives !== 2'd3 ||
            score_bcd !== 8'h00 || ball_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start state=%b still=%b lives=%0d score=%h ball=%b expected 01 0 3 00 1",
                     game_state, gra_still, lives, score_bcd, ball_reset);
        end
        step(2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ball_reset !== 1'b0 || game_state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL start_pulse ball=%b state=%b expected 0 01", ball_reset, game_state);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_score();
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2))
                step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            step(2'b00, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            checks++;
            if (score_bcd !== to_bcd(m_score)) begin
                errors++;
                $display("[TB] FAIL score_hit%0d got %h expected %h", i + 1, score_bcd, to_bcd(m_score));
            end
            if (i == 11 || i == 98 || i == 99) begin
                checks++;
                if (score_bcd !== ((i == 11) ? 8'h12 : (i == 98) ? 8'h99 : 8'h00)) begin
                    errors++;
                    $display("[TB] FAIL score_mark%0d got %h", i + 1, score_bcd);
                end
            end
        end
    endtask

    // Miss (with a coincident tick that must not count), then the countdown.
    task automatic countdown(input int exp_state, input string tag);
        for (int i = 1; i <= WAIT_P; i++) begin
            repeat ($urandom_range(0, 1))
                step(2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step(2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == WAIT_P - 1 || i == WAIT_P) begin
                checks++;
                if (game_state !== 2'((i == WAIT_P) ? exp_state : m_state) ||
                    game_state !== 2'(m_state) || gra_still !== (m_state != M_PLAY)) begin
                    errors++;
                    $display("[TB] FAIL %s_tick%0d state=%b still=%b expected %0d", tag, i,
                             game_state, gra_still, m_state);
                end
            end
        end
    endtask

    task automatic test_miss_countdown();
        step(2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (game_state !== 2'b10 || lives !== 2'd2 || ball_reset !== 1'b1 || gra_still !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss1 state=%b lives=%0d ball=%b still=%b expected 10 2 1 1",
                     game_state, lives, ball_reset, gra_still);
        end
        countdown(M_PLAY, "newball1");
        checks++;
        if (game_state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL newball1_exit state=%b expected 01", game_state);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hit_miss();
        repeat (5) step(2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (score_bcd !== 8'h05 || lives !== 2'd1 || game_state !== 2'b10) begin
            errors++;
            $display("[TB] FAIL hit_miss score=%h lives=%0d state=%b expected 05 1 10",
                     score_bcd, lives, game_state);
        end
        countdown(M_PLAY, "newball2");
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_game_over();
        step(2'b00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (game_state !== 2'b11 || lives !== 2'd0 || score_bcd !== 8'h05 || ball_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL over_entry state=%b lives=%0d score=%h ball=%b expected 11 0 05 0",
                     game_state, lives, score_bcd, ball_reset);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'b11 || score_bcd !== 8'h05) begin
            errors++;
            $display("[TB] FAIL over_press state=%b score=%h expected 11 05", game_state, score_bcd);
        end
        countdown(M_NEWGAME, "over");
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'b01 || lives !== 2'd3 || score_bcd !== 8'h00 || ball_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart state=%b lives=%0d score=%h ball=%b expected 01 3 00 1",
                     game_state, lives, score_bcd, ball_reset);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(2'b00, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        repeat (WAIT_P - 50) step(2'b00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'b10 || m_timer != 50) begin
            errors++;
            $display("[TB] FAIL mid_setup state=%b expected 10", game_state);
        end
        btn = 2'b10;
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (game_state !== 2'b00 || gra_still !== 1'b1 || ball_reset !== 1'b0 ||
            lives !== 2'd3 || score_bcd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset state=%b still=%b ball=%b lives=%0d score=%h expected 00 1 0 3 00",
                     game_state, gra_still, ball_reset, lives, score_bcd);
        end
        repeat (3) @(posedge clk);
        #5 reset = 1'b0;
        step(2'b10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (game_state !== 2'b01 || ball_reset !== 1'b1 || gra_still !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_btn state=%b ball=%b still=%b expected 01 1 0",
                     game_state, ball_reset, gra_still);
        end
    endtask

    task automatic test_random_play();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 40) == 0));
            checks++;
            if (game_state !== 2'(m_state) || gra_still !== (m_state != M_PLAY) ||
                ball_reset !== m_ball || lives !== 2'(m_lives) || score_bcd !== to_bcd(m_score)) begin
                errors++;
                $display("[TB] FAIL rand_c%0d got st=%b still=%b ball=%b lives=%0d score=%h expected st=%0d ball=%b lives=%0d score=%h",
                         c, game_state, gra_still, ball_reset, lives, score_bcd,
                         m_state, m_ball, m_lives, to_bcd(m_score));
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_score();
        test_miss_countdown();
        test_hit_miss();
        test_game_over();
        test_reset_mid();
        test_random_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
